// File: rtl/tmds_rx_channel.sv
// Single-channel TMDS receiver: deserializes an LSB-first bit stream, hunts for the
// symbol boundary on control-token runs and decodes data/control. Optional stats: TMDS_RX_STATS_EN.
//
// state  | meaning
// SEARCH | boundary unknown; counting token runs, slipping one bit per expired window
// LOCKED | boundary acquired; emitting decoded symbols, dropping lock on a token-free window
module tmds_rx_channel #(
   parameter int LOCK_TOKENS = 8,
   parameter int WINDOW_SYMS = 1024
) (
   input  logic        clk_250,
   input  logic        rst_n,
   input  logic        tmds_in,
   output logic        sym_valid,
   output logic        vde,
   output logic [7:0]  vd,
   output logic [1:0]  cd,
   output logic        locked,
   output logic        slip
`ifdef TMDS_RX_STATS_EN
   ,
   output logic [15:0] lock_loss_cnt,
   output logic [15:0] slip_cnt
`endif
);

   localparam int WW = $clog2(WINDOW_SYMS + 1);
   localparam int TW = $clog2(LOCK_TOKENS + 1);

   typedef enum logic {
      S_SEARCH = 1'b0,
      S_LOCKED = 1'b1
   } state_t;

   state_t        state, state_nxt;
   // sr[0] of the conceptual 10-bit shifter is never read, so only bits 9..1 are kept
   logic [9:1]    sr;
   logic [9:0]    sym;
   logic [3:0]    ph;
   logic          bnd;
   logic [TW-1:0] tok_cnt, tok_nxt, tok_inc;
   logic [WW-1:0] win_cnt, win_nxt, win_inc;
   logic          slip_nxt, valid_nxt;
   logic          is_tok;
   logic [1:0]    tok_cd;
   logic [7:0]    d_pre, dec;

   always_comb begin
      is_tok = 1'b1;
      tok_cd = 2'b00;
      case (sym)
         10'h354: tok_cd = 2'b00;
         10'h0AB: tok_cd = 2'b01;
         10'h154: tok_cd = 2'b10;
         10'h2AB: tok_cd = 2'b11;
         default: is_tok = 1'b0;
      endcase
   end

   assign d_pre = sym[9] ? ~sym[7:0] : sym[7:0];
   assign dec   = {d_pre[7:1] ^ d_pre[6:0] ^ {7{~sym[8]}}, d_pre[0]};

   assign tok_inc = (tok_cnt == TW'(LOCK_TOKENS)) ? tok_cnt : tok_cnt + TW'(1);
   assign win_inc = (win_cnt == WW'(WINDOW_SYMS)) ? win_cnt : win_cnt + WW'(1);

   always_comb begin
      state_nxt = state;
      tok_nxt   = tok_cnt;
      win_nxt   = win_cnt;
      slip_nxt  = 1'b0;
      valid_nxt = 1'b0;
      if (bnd) begin
         case (state)
            S_SEARCH: begin
               tok_nxt = is_tok ? tok_inc : '0;
               win_nxt = win_inc;
               // lock takes priority over a window expiring on the same symbol
               if (is_tok && tok_inc == TW'(LOCK_TOKENS)) begin
                  state_nxt = S_LOCKED;
                  tok_nxt   = '0;
                  win_nxt   = '0;
               end else if (win_inc == WW'(WINDOW_SYMS)) begin
                  slip_nxt = 1'b1;
                  tok_nxt  = '0;
                  win_nxt  = '0;
               end
            end
            S_LOCKED: begin
               if (is_tok) begin
                  win_nxt   = '0;
                  valid_nxt = 1'b1;
               end else if (win_inc == WW'(WINDOW_SYMS)) begin
                  state_nxt = S_SEARCH;
                  slip_nxt  = 1'b1;
                  tok_nxt   = '0;
                  win_nxt   = '0;
               end else begin
                  win_nxt   = win_inc;
                  valid_nxt = 1'b1;
               end
            end
            default: state_nxt = S_SEARCH;
         endcase
      end
   end

   always_ff @(posedge clk_250 or negedge rst_n) begin
      if (!rst_n) begin
         sr        <= '0;
         sym       <= '0;
         ph        <= '0;
         bnd       <= 1'b0;
         state     <= S_SEARCH;
         tok_cnt   <= '0;
         win_cnt   <= '0;
         sym_valid <= 1'b0;
         slip      <= 1'b0;
         vde       <= 1'b0;
         vd        <= '0;
         cd        <= '0;
      end else begin
         sr  <= {tmds_in, sr[9:2]};
         bnd <= (ph == 4'd9);
         if (ph == 4'd9) sym <= {tmds_in, sr[9:1]};
         // a slip holds the phase for one bit, pushing every later boundary back
         if (!slip_nxt) ph <= (ph == 4'd9) ? 4'd0 : ph + 4'd1;
         state     <= state_nxt;
         tok_cnt   <= tok_nxt;
         win_cnt   <= win_nxt;
         sym_valid <= valid_nxt;
         slip      <= slip_nxt;
         if (valid_nxt) begin
            vde <= ~is_tok;
            if (is_tok) cd <= tok_cd;
            else        vd <= dec;
         end
      end
   end

   assign locked = (state == S_LOCKED);

`ifdef TMDS_RX_STATS_EN
   always_ff @(posedge clk_250 or negedge rst_n) begin
      if (!rst_n) begin
         lock_loss_cnt <= '0;
         slip_cnt      <= '0;
      end else begin
         if (slip_nxt && state == S_LOCKED && lock_loss_cnt != 16'hFFFF)
            lock_loss_cnt <= lock_loss_cnt + 16'd1;
         if (slip_nxt && slip_cnt != 16'hFFFF)
            slip_cnt <= slip_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_tmds_rx_channel.sv
// Bench for tmds_rx_channel: encodes symbol streams with a TMDS encoder model, serializes
// them LSB first and compares the decoded output stream with the encoder's own inputs.
module tb_tmds_rx_channel;

   localparam int LOCK_TOKENS = 8;
   localparam int WINDOW_SYMS = 1024;

   logic        clk_250 = 1'b0;
   logic        rst_n = 1'b0;
   logic        tmds_in = 1'b0;
   logic        sym_valid, vde, locked, slip;
   logic [7:0]  vd;
   logic [1:0]  cd;
`ifdef TMDS_RX_STATS_EN
   logic [15:0] lock_loss_cnt, slip_cnt;
`endif

   tmds_rx_channel #(.LOCK_TOKENS(LOCK_TOKENS), .WINDOW_SYMS(WINDOW_SYMS)) dut (
      .clk_250   (clk_250),
      .rst_n     (rst_n),
      .tmds_in   (tmds_in),
      .sym_valid (sym_valid),
      .vde       (vde),
      .vd        (vd),
      .cd        (cd),
      .locked    (locked),
      .slip      (slip)
`ifdef TMDS_RX_STATS_EN
      ,
      .lock_loss_cnt (lock_loss_cnt),
      .slip_cnt      (slip_cnt)
`endif
   );

   always #5 clk_250 = ~clk_250;

   int n_pass = 0;
   int n_fail = 0;
   int cyc;
   int rd_cnt;

   // transmitted stream: encoded word, control flag and the encoder's input value
   logic [9:0] s_sym[$];
   bit         s_ctrl[$];
   logic [7:0] s_val[$];

   logic       o_vde[$];
   logic [7:0] o_vd[$];
   logic [1:0] o_cd[$];
   int         slip_cyc[$];

   logic       exp_vde[$];
   logic [7:0] exp_vd[$];
   logic [1:0] exp_cd[$];

   always @(posedge clk_250 or negedge rst_n)
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;

   always @(negedge clk_250) begin
      if (rst_n) begin
         if (sym_valid) begin
            o_vde.push_back(vde);
            o_vd.push_back(vd);
            o_cd.push_back(cd);
         end
         if (slip) slip_cyc.push_back(cyc);
      end
   end

   function automatic logic [9:0] tmds_encode(input logic [7:0] d);
      logic [8:0] qm;
      logic [9:0] q;
      int n1d, n1q, n0q;
      n1d = $countones(d);
      qm[0] = d[0];
      if (n1d > 4 || (n1d == 4 && !d[0])) begin
         for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
         qm[8] = 1'b0;
      end else begin
         for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
         qm[8] = 1'b1;
      end
      n1q = $countones(qm[7:0]);
      n0q = 8 - n1q;
      if (rd_cnt == 0 || n1q == n0q) begin
         q = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
         rd_cnt = qm[8] ? rd_cnt + n1q - n0q : rd_cnt + n0q - n1q;
      end else if ((rd_cnt > 0 && n1q > n0q) || (rd_cnt < 0 && n0q > n1q)) begin
         q = {1'b1, qm[8], ~qm[7:0]};
         rd_cnt = rd_cnt + (qm[8] ? 2 : 0) + n0q - n1q;
      end else begin
         q = {1'b0, qm[8], qm[7:0]};
         rd_cnt = rd_cnt - (qm[8] ? 0 : 2) + n1q - n0q;
      end
      return q;
   endfunction

   // encoder front half with the transition mode and the inversion chosen by the caller
   function automatic logic [9:0] make_sym(input logic [7:0] d, input bit xor_mode, input bit inv);
      logic [7:0] qm;
      qm[0] = d[0];
      for (int i = 1; i < 8; i++) qm[i] = xor_mode ? (qm[i-1] ^ d[i]) : ~(qm[i-1] ^ d[i]);
      return {inv, xor_mode, inv ? ~qm : qm};
   endfunction

   function automatic logic [9:0] token(input logic [1:0] c);
      case (c)
         2'b00:   return 10'h354;
         2'b01:   return 10'h0AB;
         2'b10:   return 10'h154;
         default: return 10'h2AB;
      endcase
   endfunction

   task automatic add_raw(input logic [9:0] w, input bit ctrl, input logic [7:0] v);
      s_sym.push_back(w);
      s_ctrl.push_back(ctrl);
      s_val.push_back(v);
   endtask

   task automatic add_data(input logic [7:0] b);
      add_raw(tmds_encode(b), 1'b0, b);
   endtask

   task automatic add_ctrl(input logic [1:0] c);
      rd_cnt = 0;
      add_raw(token(c), 1'b1, {6'd0, c});
   endtask

   task automatic add_lines(input int nlines);
      for (int y = 0; y < nlines; y++)
         for (int x = 0; x < 800; x++)
            if (x < 640) add_data(8'($urandom_range(0, 255)));
            else         add_ctrl({1'b1, !(x >= 656 && x < 752)});
   endtask

   task automatic clear_stream();
      s_sym.delete();
      s_ctrl.delete();
      s_val.delete();
      rd_cnt = 0;
   endtask

   task automatic clear_obs();
      o_vde.delete();
      o_vd.delete();
      o_cd.delete();
      slip_cyc.delete();
   endtask

   task automatic send_bit(input logic b);
      tmds_in = b;
      @(negedge clk_250);
   endtask

   task automatic send_stream(input int pre_bits, input int flush_bits);
      for (int i = 0; i < pre_bits; i++) send_bit(1'b0);
      foreach (s_sym[k])
         for (int b = 0; b < 10; b++) send_bit(s_sym[k][b]);
      for (int i = 0; i < flush_bits; i++) send_bit(1'b0);
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      tmds_in = 1'b0;
      repeat (3) @(negedge clk_250);
      clear_obs();
      rst_n = 1'b1;
   endtask

   // index of the symbol completing the first run of LOCK_TOKENS tokens at or after 'from'
   function automatic int find_lock(input int from);
      int run = 0;
      for (int i = from; i < s_sym.size(); i++) begin
         run = s_ctrl[i] ? run + 1 : 0;
         if (run == LOCK_TOKENS) return i;
      end
      return s_sym.size();
   endfunction

   // after lock every symbol is reported; vd/cd hold their last value across the other kind
   task automatic build_expected(input int lock_idx);
      logic [7:0] hv = 8'h00;
      logic [1:0] hc = 2'b00;
      exp_vde.delete();
      exp_vd.delete();
      exp_cd.delete();
      for (int i = lock_idx + 1; i < s_sym.size(); i++) begin
         if (s_ctrl[i]) hc = s_val[i][1:0];
         else           hv = s_val[i];
         exp_vde.push_back(!s_ctrl[i]);
         exp_vd.push_back(hv);
         exp_cd.push_back(hc);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tmds_in = 1'b1;
      repeat (2) @(negedge clk_250);
      if ({sym_valid, vde, vd, cd, locked, slip} !== 14'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got sv=%b vde=%b vd=%h cd=%b lk=%b slip=%b want all zero",
                  sym_valid, vde, vd, cd, locked, slip);
      end else n_pass++;
      do_reset();
      repeat (5) send_bit(1'b1);
      if ({sym_valid, locked, slip} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_idle: got sv=%b lk=%b slip=%b want 000", sym_valid, locked, slip);
      end else n_pass++;
   endtask

   task automatic test_frame_aligned();
      int n;
      do_reset();
      clear_stream();
      add_lines(2);
      send_stream(0, 3);
      build_expected(find_lock(0));
      n = exp_vd.size();
      if (locked !== 1'b1) begin
         n_fail++;
         $display("FAIL aligned_locked: got %b want 1", locked);
      end else n_pass++;
      if (slip_cyc.size() != 0) begin
         n_fail++;
         $display("FAIL aligned_slips: got %0d want 0", slip_cyc.size());
      end else n_pass++;
      if (o_vd.size() != n) begin
         n_fail++;
         $display("FAIL aligned_count: got %0d want %0d", o_vd.size(), n);
      end else n_pass++;
      for (int i = 0; i < n && i < o_vd.size(); i++)
         if (o_vde[i] !== exp_vde[i] || o_vd[i] !== exp_vd[i] || o_cd[i] !== exp_cd[i]) begin
            n_fail++;
            $display("FAIL aligned_sym%0d: got vde=%b vd=%h cd=%b want vde=%b vd=%h cd=%b",
                     i, o_vde[i], o_vd[i], o_cd[i], exp_vde[i], exp_vd[i], exp_cd[i]);
         end else n_pass++;
   endtask

   task automatic test_frame_offset();
      int n;
      do_reset();
      clear_stream();
      add_lines(4);
      send_stream(3, 3);
      if (slip_cyc.size() != 3) begin
         n_fail++;
         $display("FAIL offset_slip_count: got %0d want 3", slip_cyc.size());
      end else n_pass++;
      if (slip_cyc.size() > 0) begin
         if (slip_cyc[0] != WINDOW_SYMS * 10 + 1) begin
            n_fail++;
            $display("FAIL offset_first_slip: got cycle %0d want %0d", slip_cyc[0], WINDOW_SYMS * 10 + 1);
         end else n_pass++;
      end
      for (int i = 1; i < slip_cyc.size(); i++)
         if (slip_cyc[i] - slip_cyc[i-1] != WINDOW_SYMS * 10 + 1) begin
            n_fail++;
            $display("FAIL offset_slip_gap%0d: got %0d want %0d", i,
                     slip_cyc[i] - slip_cyc[i-1], WINDOW_SYMS * 10 + 1);
         end else n_pass++;
      // after three slips boundary n carries stream symbol n
      build_expected(find_lock(3 * WINDOW_SYMS));
      n = exp_vd.size();
      if (o_vd.size() != n) begin
         n_fail++;
         $display("FAIL offset_count: got %0d want %0d", o_vd.size(), n);
      end else n_pass++;
      for (int i = 0; i < n && i < o_vd.size(); i++)
         if (o_vde[i] !== exp_vde[i] || o_vd[i] !== exp_vd[i] || o_cd[i] !== exp_cd[i]) begin
            n_fail++;
            $display("FAIL offset_sym%0d: got vde=%b vd=%h cd=%b want vde=%b vd=%h cd=%b",
                     i, o_vde[i], o_vd[i], o_cd[i], exp_vde[i], exp_vd[i], exp_cd[i]);
         end else n_pass++;
   endtask

   task automatic test_decode_patterns();
      logic [7:0] pats[4] = '{8'hFF, 8'h00, 8'h55, 8'hAA};
      int n;
      do_reset();
      clear_stream();
      for (int i = 0; i < LOCK_TOKENS; i++) add_ctrl(2'b11);
      foreach (pats[p])
         for (int xm = 0; xm < 2; xm++)
            for (int inv = 0; inv < 2; inv++)
               add_raw(make_sym(pats[p], xm[0], inv[0]), 1'b0, pats[p]);
      for (int c = 0; c < 4; c++) add_ctrl(2'(c));
      for (int i = 0; i < 20; i++) add_data(8'($urandom_range(0, 255)));
      add_ctrl(2'b10);
      add_data(8'($urandom_range(0, 255)));
      send_stream(0, 3);
      build_expected(find_lock(0));
      n = exp_vd.size();
      if (o_vd.size() != n) begin
         n_fail++;
         $display("FAIL decode_count: got %0d want %0d", o_vd.size(), n);
      end else n_pass++;
      for (int i = 0; i < n && i < o_vd.size(); i++)
         if (o_vde[i] !== exp_vde[i] || o_vd[i] !== exp_vd[i] || o_cd[i] !== exp_cd[i]) begin
            n_fail++;
            $display("FAIL decode_sym%0d: got vde=%b vd=%h cd=%b want vde=%b vd=%h cd=%b",
                     i, o_vde[i], o_vd[i], o_cd[i], exp_vde[i], exp_vd[i], exp_cd[i]);
         end else n_pass++;
   endtask

   task automatic test_window_drop();
      int bad = 0;
      do_reset();
      clear_stream();
      for (int i = 0; i < LOCK_TOKENS; i++) add_ctrl(2'b00);
      // 0x1FF: XOR mode, no inversion, q_m = 0xFF, which encodes the byte 0x01
      for (int i = 0; i < WINDOW_SYMS; i++) add_raw(10'h1FF, 1'b0, 8'h01);
      send_stream(0, 3);
      if (o_vd.size() != WINDOW_SYMS - 1) begin
         n_fail++;
         $display("FAIL drop_valid_count: got %0d want %0d", o_vd.size(), WINDOW_SYMS - 1);
      end else n_pass++;
      foreach (o_vd[i]) if (o_vd[i] !== 8'h01 || o_vde[i] !== 1'b1) bad++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL drop_data: got %0d wrong symbols want 0", bad);
      end else n_pass++;
      if (locked !== 1'b0) begin
         n_fail++;
         $display("FAIL drop_locked: got %b want 0", locked);
      end else n_pass++;
      if (slip_cyc.size() != 1) begin
         n_fail++;
         $display("FAIL drop_slip_count: got %0d want 1", slip_cyc.size());
      end else n_pass++;
      if (slip_cyc.size() > 0) begin
         if (slip_cyc[0] != (LOCK_TOKENS + WINDOW_SYMS) * 10 + 1) begin
            n_fail++;
            $display("FAIL drop_slip_time: got cycle %0d want %0d", slip_cyc[0],
                     (LOCK_TOKENS + WINDOW_SYMS) * 10 + 1);
         end else n_pass++;
      end
      clear_stream();
      for (int i = 0; i < 20; i++) add_raw(10'h1FF, 1'b0, 8'h01);
      send_stream(0, 3);
      if (o_vd.size() != WINDOW_SYMS - 1) begin
         n_fail++;
         $display("FAIL drop_valid_stops: got %0d want %0d", o_vd.size(), WINDOW_SYMS - 1);
      end else n_pass++;
   endtask

   task automatic test_reset_mid_symbol();
      logic [7:0] b;
      int n;
      b = 8'($urandom_range(1, 255));
      do_reset();
      clear_stream();
      for (int i = 0; i < LOCK_TOKENS; i++) add_ctrl(2'b01);
      add_data(b);
      add_ctrl(2'b01);
      send_stream(0, 0);
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      if (locked !== 1'b1 || vd !== b || cd !== 2'b01) begin
         n_fail++;
         $display("FAIL midrst_before: got lk=%b vd=%h cd=%b want lk=1 vd=%h cd=01", locked, vd, cd, b);
      end else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      if ({sym_valid, vde, vd, cd, locked, slip} !== 14'd0) begin
         n_fail++;
         $display("FAIL midrst_async: got sv=%b vde=%b vd=%h cd=%b lk=%b slip=%b want all zero",
                  sym_valid, vde, vd, cd, locked, slip);
      end else n_pass++;
      tmds_in = 1'b0;
      repeat (2) @(negedge clk_250);
      clear_obs();
      rst_n = 1'b1;
      clear_stream();
      for (int i = 0; i < LOCK_TOKENS - 1; i++) add_ctrl(2'b10);
      add_data(8'($urandom_range(0, 255)));
      for (int i = 0; i < LOCK_TOKENS; i++) add_ctrl(2'b10);
      add_data(8'($urandom_range(0, 255)));
      add_data(8'($urandom_range(0, 255)));
      send_stream(0, 3);
      build_expected(find_lock(0));
      n = exp_vd.size();
      if (o_vd.size() != n) begin
         n_fail++;
         $display("FAIL midrst_reacq_count: got %0d want %0d", o_vd.size(), n);
      end else n_pass++;
      for (int i = 0; i < n && i < o_vd.size(); i++)
         if (o_vde[i] !== exp_vde[i] || o_vd[i] !== exp_vd[i] || o_cd[i] !== exp_cd[i]) begin
            n_fail++;
            $display("FAIL midrst_sym%0d: got vde=%b vd=%h cd=%b want vde=%b vd=%h cd=%b",
                     i, o_vde[i], o_vd[i], o_cd[i], exp_vde[i], exp_vd[i], exp_cd[i]);
         end else n_pass++;
   endtask

`ifdef TMDS_RX_STATS_EN
   task automatic test_stats();
      do_reset();
      for (int k = 0; k < 3; k++) begin
         clear_stream();
         for (int i = 0; i < LOCK_TOKENS; i++) add_ctrl(2'b11);
         for (int i = 0; i < WINDOW_SYMS; i++) add_raw(10'h1FF, 1'b0, 8'h01);
         // each drop slips one bit and the 3 flush bits move the stream by 3; 8 more realigns
         send_stream(k == 0 ? 0 : 8, 3);
      end
      if (slip_cyc.size() != 3) begin
         n_fail++;
         $display("FAIL stats_slip_pulses: got %0d want 3", slip_cyc.size());
      end else n_pass++;
      if (lock_loss_cnt !== 16'd3) begin
         n_fail++;
         $display("FAIL stats_lock_loss: got %0d want 3", lock_loss_cnt);
      end else n_pass++;
      if (slip_cnt !== 16'd3) begin
         n_fail++;
         $display("FAIL stats_slip_cnt: got %0d want 3", slip_cnt);
      end else n_pass++;
   endtask
`endif

   initial begin
      test_reset();
      test_frame_aligned();
      test_frame_offset();
      test_decode_patterns();
      test_window_drop();
      test_reset_mid_symbol();
`ifdef TMDS_RX_STATS_EN
      test_stats();
`endif
      $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
      $finish;
   end

endmodule
